// File: rtl/inverter_arbiter_pkg.sv
// Shared constants and state type for the round-robin inverter arbiter.
package inv_arb_pkg;

    localparam int DEF_N   = 4;
    localparam int DEF_W   = 8;
    localparam int DEF_IDW = 2;
    localparam int STAT_W  = 16;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arbState_t;

endpackage

// File: rtl/inverter_arbiter_if.sv
// Request/response bundle between N producers, the arbiter and one consumer.
interface inverter_arbiter_if
    import inv_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = DEF_IDW
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [W-1:0]   resp_data;
    logic [IDW-1:0] resp_id;
    logic           resp_ready;
    logic           busy;

    // The arbiter side of the bundle.
    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, busy
    );

    // Producers and consumer side of the bundle.
    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/inverter_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after i_ptr, wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_valid,
    input  logic [IDW-1:0] i_ptr,
    input  logic           i_enable,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    int cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(i_ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (i_enable && !o_any && i_valid[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/inverter_arbiter.sv
// N-way round-robin arbiter feeding one registered bitwise-NOT stage and a single-entry response buffer.
// Define INV_ARB_STATS_EN to add the grant_count / stall_count statistics outputs.
module inverter_arbiter
    import inv_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = DEF_IDW
) (
    input  logic              clock,
    input  logic              reset,
`ifdef INV_ARB_STATS_EN
    output logic [STAT_W-1:0] grant_count,
    output logic [STAT_W-1:0] stall_count,
`endif
    inverter_arbiter_if.slave bus
);

    arbState_t      r_state;
    arbState_t      w_nextState;
    logic [IDW-1:0] r_ptr;
    logic [W-1:0]   r_respData;
    logic [IDW-1:0] r_respId;

    logic           w_canAccept;
    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic           w_xfer;
    logic [W-1:0]   w_selData;

    // A drain in the same cycle frees the buffer, so a full buffer can still accept.
    assign w_canAccept = (r_state == ARB_EMPTY) || bus.resp_ready;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_valid  (bus.req_valid),
        .i_ptr    (r_ptr),
        .i_enable (w_canAccept),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign bus.req_ready = w_grant;
    assign w_xfer        = w_any;

    always_comb begin
        w_selData = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(w_idx)) begin
                w_selData = bus.req_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARB_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARB_EMPTY: if (w_xfer) w_nextState = ARB_FULL;
            ARB_FULL:  if (bus.resp_ready && !w_xfer) w_nextState = ARB_EMPTY;
            default:   w_nextState = ARB_EMPTY;
        endcase
    end

    always_comb begin
        bus.resp_valid = (r_state == ARB_FULL);
        bus.busy       = (r_state == ARB_FULL);
        bus.resp_data  = r_respData;
        bus.resp_id    = r_respId;
    end

    // Data and pointer move only on a transfer; a plain drain leaves the last word visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_respData <= '0;
            r_respId   <= '0;
            r_ptr      <= IDW'(N - 1);
        end else if (w_xfer) begin
            r_respData <= ~w_selData;
            r_respId   <= w_idx;
            r_ptr      <= w_idx;
        end
    end

`ifdef INV_ARB_STATS_EN
    logic [STAT_W-1:0] r_grantCount;
    logic [STAT_W-1:0] r_stallCount;

    // Grant counter wraps; stall counter saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grantCount <= '0;
            r_stallCount <= '0;
        end else begin
            if (w_xfer) begin
                r_grantCount <= r_grantCount + 1'b1;
            end
            if ((r_state == ARB_FULL) && !bus.resp_ready && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
        end
    end

    assign grant_count = r_grantCount;
    assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_inverter_arbiter.sv
// Directed self-checking bench for inverter_arbiter (N=4, W=8); stats checks under INV_ARB_STATS_EN.
module tb_inverter_arbiter;
    import inv_arb_pkg::*;

    logic clock;
    logic reset;
    int   checkCount;
    int   passCount;

    inverter_arbiter_if #(.N(4), .W(8), .IDW(2)) bus();

`ifdef INV_ARB_STATS_EN
    logic [STAT_W-1:0] grantCount;
    logic [STAT_W-1:0] stallCount;
`endif

    inverter_arbiter #(
        .N   (4),
        .W   (8),
        .IDW (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef INV_ARB_STATS_EN
        .grant_count (grantCount),
        .stall_count (stallCount),
`endif
        .bus         (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic respReady);
        bus.req_valid  = valid;
        bus.req_data   = data;
        bus.resp_ready = respReady;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic resetDut();
        applyStimulus(4'b0000, 32'h0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
        #3;
        checkOutput("rst_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_data",  32'(bus.resp_data),  32'h0);
        checkOutput("rst_id",    32'(bus.resp_id),    32'd0);
        checkOutput("rst_busy",  32'(bus.busy),       32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready),  32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Single requester accept and latency
        applyStimulus(4'b0001, 32'h0000_003C, 1'b1);
        checkOutput("t1_ready", 32'(bus.req_ready), 32'b0001);
        step();
        checkOutput("t1_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("t1_data",  32'(bus.resp_data),  32'hC3);
        checkOutput("t1_id",    32'(bus.resp_id),    32'd0);
        applyStimulus(4'b0000, 32'h0, 1'b1);
        step();
        checkOutput("t1_drain_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("t1_drain_hold",  32'(bus.resp_data),  32'hC3);

        // Round robin with all requesters, no bubbles
        resetDut();
        applyStimulus(4'b1111, 32'h4433_2211, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
            step();
            checkOutput("rr_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("rr_id",    32'(bus.resp_id),    32'(k % 4));
            checkOutput("rr_data",  32'(bus.resp_data),  32'(8'hFF - 8'(8'h11 * ((k % 4) + 1))));
        end

        // Backpressure stall
        resetDut();
        applyStimulus(4'b0001, 32'h0000_00F0, 1'b1);
        step();
        applyStimulus(4'b1111, 32'h1234_56F0, 1'b0);
        checkOutput("stall_ready", 32'(bus.req_ready), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("stall_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("stall_data",  32'(bus.resp_data),  32'h0F);
            checkOutput("stall_id",    32'(bus.resp_id),    32'd0);
            checkOutput("stall_rdy",   32'(bus.req_ready),  32'h0);
        end
`ifdef INV_ARB_STATS_EN
        checkOutput("stall_count", 32'(stallCount), 32'd5);
        checkOutput("grant_count", 32'(grantCount), 32'd1);
`endif

        // Requesters 1 and 3 with ptr=1
        resetDut();
        applyStimulus(4'b0010, 32'h0000_0000, 1'b1);
        step();
        checkOutput("p1_id", 32'(bus.resp_id), 32'd1);
        applyStimulus(4'b1010, 32'hAA00_0000, 1'b1);
        checkOutput("p13_ready0", 32'(bus.req_ready), 32'b1000);
        step();
        checkOutput("p13_id0",    32'(bus.resp_id),   32'd3);
        checkOutput("p13_data0",  32'(bus.resp_data), 32'h55);
        checkOutput("p13_ready1", 32'(bus.req_ready), 32'b0010);
        step();
        checkOutput("p13_id1",    32'(bus.resp_id),   32'd1);
        checkOutput("p13_data1",  32'(bus.resp_data), 32'hFF);

        // Asynchronous reset while full
        resetDut();
        applyStimulus(4'b0100, 32'h005A_0000, 1'b1);
        step();
        checkOutput("ar_full_id", 32'(bus.resp_id), 32'd2);
        applyStimulus(4'b0000, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("ar_data",  32'(bus.resp_data),  32'h0);
        checkOutput("ar_ready", 32'(bus.req_ready),  32'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(4'b1111, 32'h0, 1'b1);
        checkOutput("ar_prio0", 32'(bus.req_ready), 32'b0001);

`ifdef INV_ARB_STATS_EN
        // Grant counter wrap
        resetDut();
        applyStimulus(4'b0001, 32'h0, 1'b1);
        repeat (65537) step();
        checkOutput("wrap_grant", 32'(grantCount), 32'd1);
        checkOutput("wrap_stall", 32'(stallCount), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
